zap_mul_arbiter: RTL and testbench

ZAP_MUL_ARBITER -- requirements
Module: zap_mul_arbiter

---
 rtl/zap_mul_arb_pkg.sv | 24 ++
 rtl/zap_mul_arb_rr.sv | 28 ++
 rtl/zap_mul_arbiter.sv | 167 ++++++++++++++++
 tb/tb_zap_mul_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_mul_arb_pkg.sv
// zap_mul_arb_pkg
//   Shared types and constants for the two-requester multiply arbiter:
//   FSM state enum, requester count, the non-multiply op encoding and a
//   small helper that picks one requester's 32-bit operand from a packed
//   per-requester bus.
package zap_mul_arb_pkg;

    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned MUL_OP_NOP = 0;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StRsp,
        StHold
    } arb_state_e;

    // Select requester `sel`'s word from a {req1, req0} packed operand bus.
    function automatic logic [31:0] sel_word(input logic [NUM_REQ*32-1:0] vec,
                                             input logic                  sel);
        return sel ? vec[63:32] : vec[31:0];
    endfunction

endpackage

// File: rtl/zap_mul_arb_rr.sv
// zap_mul_arb_rr
//   Two-way grant selector. The requester named by ptr_i has priority; the
//   other one wins only when the preferred requester is idle.
//   Ports:
//     req_i  request vector
//     ptr_i  index of the preferred requester
//     gnt_o  one-hot grant (all zero when nothing is requested)
module zap_mul_arb_rr
    import zap_mul_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic alt;
    assign alt = ~ptr_i;

    always_comb begin
        gnt_o = '0;
        if (req_i[ptr_i]) begin
            gnt_o[ptr_i] = 1'b1;
        end else if (req_i[alt]) begin
            gnt_o[alt] = 1'b1;
        end
    end

endmodule

// File: rtl/zap_mul_arbiter.sv
// zap_mul_arbiter
//   Shares one multiplier between two requesters. A grant captures the
//   winner's op and operands, the captured op is presented to the multiplier
//   until it completes, the result is registered and returned to the owner as
//   a one-cycle response. A requester that sets i_lock keeps ownership for a
//   following dependent op, up to LOCK_MAX consecutive grants.
//   Build option: define ZAP_MUL_ARB_RR_EN for round-robin tie-break; without
//   it requester 0 always wins a tie and no pointer state exists.
//   Ports:
//     i_clk, i_reset_n              clock, async active-low reset
//     i_clear                       flush; abandons the current operation
//     i_req/i_op/i_rm/rn/rh/rs      per-requester request, op and operands
//     i_lock                        per-requester keep-ownership request
//     o_gnt                         one-hot grant pulse (capture cycle)
//     o_rsp_vld, o_rd/sat/nozero    one-hot response pulse and result
//     o_mul_go, o_mul_op, o_mul_*   operation presented to the multiplier
//     i_mul_done, i_mul_rd/sat/nz   multiplier completion and result
module zap_mul_arbiter
    import zap_mul_arb_pkg::*;
#(
    parameter  int unsigned ALU_OPS  = 32,
    parameter  int unsigned LOCK_MAX = 3,   // must be >= 1
    localparam int unsigned OPW      = $clog2(ALU_OPS)
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_clear,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [NUM_REQ*OPW-1:0] i_op,
    input  logic [NUM_REQ*32-1:0]  i_rm,
    input  logic [NUM_REQ*32-1:0]  i_rn,
    input  logic [NUM_REQ*32-1:0]  i_rh,
    input  logic [NUM_REQ*32-1:0]  i_rs,
    input  logic [NUM_REQ-1:0]     i_lock,
    output logic [NUM_REQ-1:0]     o_gnt,
    output logic [NUM_REQ-1:0]     o_rsp_vld,
    output logic [31:0]            o_rd,
    output logic                   o_sat,
    output logic                   o_nozero,
    output logic                   o_mul_go,
    output logic [OPW-1:0]         o_mul_op,
    output logic [31:0]            o_mul_rm,
    output logic [31:0]            o_mul_rn,
    output logic [31:0]            o_mul_rh,
    output logic [31:0]            o_mul_rs,
    input  logic                   i_mul_done,
    input  logic [31:0]            i_mul_rd,
    input  logic                   i_mul_sat,
    input  logic                   i_mul_nozero
);

    localparam int unsigned CNTW = $clog2(LOCK_MAX + 1);

    arb_state_e        state_q;
    logic              owner_q;
    logic              lock_q;
    logic [CNTW-1:0]   cnt_q;
    logic [OPW-1:0]    op_q;
    logic [31:0]       rm_q, rn_q, rh_q, rs_q;
    logic [31:0]       rd_q;
    logic              sat_q, nozero_q;

    logic [NUM_REQ-1:0] rr_gnt;
    logic [NUM_REQ-1:0] gnt;
    logic               rr_ptr;
    logic               win;

`ifdef ZAP_MUL_ARB_RR_EN
    logic ptr_q;
    assign rr_ptr = ptr_q;
`else
    assign rr_ptr = 1'b0;
`endif

    zap_mul_arb_rr u_rr (
        .req_i (i_req),
        .ptr_i (rr_ptr),
        .gnt_o (rr_gnt)
    );

    // Grants are only issued while idle, or to the owner while held.
    always_comb begin
        gnt = '0;
        unique case (state_q)
            StIdle:  gnt = rr_gnt;
            StHold:  gnt[owner_q] = i_req[owner_q];
            default: gnt = '0;
        endcase
        if (i_clear || !i_reset_n) begin
            gnt = '0;
        end
    end

    assign win = gnt[1];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            lock_q   <= 1'b0;
            cnt_q    <= '0;
            op_q     <= '0;
            rm_q     <= '0;
            rn_q     <= '0;
            rh_q     <= '0;
            rs_q     <= '0;
            rd_q     <= '0;
            sat_q    <= 1'b0;
            nozero_q <= 1'b0;
`ifdef ZAP_MUL_ARB_RR_EN
            ptr_q    <= 1'b0;
`endif
        end else if (i_clear) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle, StHold: begin
                    if (|gnt) begin
                        state_q <= StRun;
                        owner_q <= win;
                        lock_q  <= i_lock[win];
                        op_q    <= win ? i_op[2*OPW-1:OPW] : i_op[OPW-1:0];
                        rm_q    <= sel_word(i_rm, win);
                        rn_q    <= sel_word(i_rn, win);
                        rh_q    <= sel_word(i_rh, win);
                        rs_q    <= sel_word(i_rs, win);
                        // cnt_q counts consecutive grants held by the owner
                        cnt_q   <= (state_q == StHold) ? cnt_q + CNTW'(1) : CNTW'(1);
`ifdef ZAP_MUL_ARB_RR_EN
                        ptr_q   <= ~win;
`endif
                    end else if (state_q == StHold) begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    if (i_mul_done) begin
                        rd_q     <= i_mul_rd;
                        sat_q    <= i_mul_sat;
                        nozero_q <= i_mul_nozero;
                        state_q  <= StRsp;
                    end
                end
                StRsp: begin
                    state_q <= (lock_q && (cnt_q < CNTW'(LOCK_MAX))) ? StHold : StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_gnt     = gnt;
    assign o_rsp_vld = (state_q == StRsp && !i_clear) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign o_rd      = rd_q;
    assign o_sat     = sat_q;
    assign o_nozero  = nozero_q;

    // go falls in the completion cycle so the multiplier never restarts.
    assign o_mul_go = (state_q == StRun) && !i_mul_done;
    assign o_mul_op = (state_q == StRun) ? op_q : OPW'(MUL_OP_NOP);
    assign o_mul_rm = rm_q;
    assign o_mul_rn = rn_q;
    assign o_mul_rh = rh_q;
    assign o_mul_rs = rs_q;

endmodule

// File: tb/tb_zap_mul_arbiter.sv
// tb_zap_mul_arbiter
//   Directed scenarios plus randomized traffic, every cycle compared with a
//   transaction-level reference model of the arbiter kept in this bench.
module tb_zap_mul_arbiter;

    localparam int unsigned OPW      = 5;
    localparam int          LOCK_MAX = 3;
    // Arbitrary nonzero op encodings used by the directed scenarios.
    localparam logic [OPW-1:0] OP_UMLALL = 5'd9;
    localparam logic [OPW-1:0] OP_SMLALL = 5'd11;
    localparam logic [OPW-1:0] OP_SMLALH = 5'd12;

    logic           clk = 1'b0;
    logic           rst_n, clear;
    logic [1:0]     req, lock;
    logic [2*OPW-1:0] op;
    logic [63:0]    rm, rn, rh, rs;
    logic [1:0]     gnt, rsp_vld;
    logic [31:0]    rd;
    logic           sat, nozero, mul_go;
    logic [OPW-1:0] mul_op;
    logic [31:0]    mul_rm, mul_rn, mul_rh, mul_rs;
    logic           mul_done, mul_sat, mul_nozero;
    logic [31:0]    mul_rd;

    always #5 clk = ~clk;

    zap_mul_arbiter #(
        .ALU_OPS  (32),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_clear      (clear),
        .i_req        (req),
        .i_op         (op),
        .i_rm         (rm),
        .i_rn         (rn),
        .i_rh         (rh),
        .i_rs         (rs),
        .i_lock       (lock),
        .o_gnt        (gnt),
        .o_rsp_vld    (rsp_vld),
        .o_rd         (rd),
        .o_sat        (sat),
        .o_nozero     (nozero),
        .o_mul_go     (mul_go),
        .o_mul_op     (mul_op),
        .o_mul_rm     (mul_rm),
        .o_mul_rn     (mul_rn),
        .o_mul_rh     (mul_rh),
        .o_mul_rs     (mul_rs),
        .i_mul_done   (mul_done),
        .i_mul_rd     (mul_rd),
        .i_mul_sat    (mul_sat),
        .i_mul_nozero (mul_nozero)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: is a multiply in flight, is a response due, which
    // requester (if any) has the next slot reserved, and how many grants in a
    // row the current owner has had.
    bit          m_busy, m_rsp, m_lock, m_sat, m_nz;
    int          m_hold, m_owner, m_streak, m_prefer;
    logic [OPW-1:0] m_op;
    logic [31:0] m_rm, m_rn, m_rh, m_rs, m_rd;

    // DUT outputs as sampled in the most recent step
    logic [1:0]     s_gnt, s_rsp;
    logic           s_go;
    logic [OPW-1:0] s_op;
    logic [31:0]    s_rd;

    task automatic model_reset();
        m_busy = 0; m_rsp = 0; m_hold = -1; m_streak = 0; m_prefer = 0; m_owner = 0;
    endtask

    // Inputs are set by the caller just after a rising edge; sample and
    // compare at the falling edge, advance the model, return after next edge.
    task automatic step();
        int win;
        logic [1:0] e_gnt, e_rsp;
        logic e_go;
        logic [OPW-1:0] e_op;
        @(negedge clk);
        s_gnt = gnt; s_rsp = rsp_vld; s_go = mul_go; s_op = mul_op; s_rd = rd;
        e_gnt = '0; e_rsp = '0; e_go = 1'b0; e_op = '0; win = -1;
        if (m_rsp) begin
            if (!clear) e_rsp = 2'b01 << m_owner;
        end else if (m_busy) begin
            e_go = !mul_done;
            e_op = m_op;
        end else if (!clear) begin
            if (m_hold >= 0) begin
                if (req[m_hold]) win = m_hold;
            end else if (req == 2'b11) begin
                win = m_prefer;
            end else if (req[0]) begin
                win = 0;
            end else if (req[1]) begin
                win = 1;
            end
        end
        if (win >= 0) e_gnt = 2'b01 << win;
        check("gnt", gnt, e_gnt);
        check("rsp_vld", rsp_vld, e_rsp);
        check("mul_go", mul_go, e_go);
        check("mul_op", mul_op, e_op);
        if (m_busy) begin
            check("mul_rm", mul_rm, m_rm);
            check("mul_rn", mul_rn, m_rn);
            check("mul_rh", mul_rh, m_rh);
            check("mul_rs", mul_rs, m_rs);
        end
        if (m_rsp && !clear) begin
            check("rd", rd, m_rd);
            check("sat_nz", {sat, nozero}, {m_sat, m_nz});
        end
        if (clear) begin
            m_busy = 0; m_rsp = 0; m_hold = -1; m_streak = 0;
        end else if (m_rsp) begin
            m_rsp  = 0;
            m_hold = (m_lock && m_streak < LOCK_MAX) ? m_owner : -1;
        end else if (m_busy) begin
            if (mul_done) begin
                m_busy = 0; m_rsp = 1;
                m_rd = mul_rd; m_sat = mul_sat; m_nz = mul_nozero;
            end
        end else begin
            if (win >= 0) begin
                m_streak = (m_hold == win) ? m_streak + 1 : 1;
                m_busy  = 1;
                m_owner = win;
                m_lock  = lock[win];
                m_op    = op[win*OPW +: OPW];
                m_rm    = rm[win*32 +: 32];
                m_rn    = rn[win*32 +: 32];
                m_rh    = rh[win*32 +: 32];
                m_rs    = rs[win*32 +: 32];
`ifdef ZAP_MUL_ARB_RR_EN
                m_prefer = 1 - win;
`endif
            end
            m_hold = -1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear = 0; req = '0; lock = '0; op = '0; rm = '0; rn = '0; rh = '0; rs = '0;
        mul_done = 0; mul_rd = '0; mul_sat = 0; mul_nozero = 0;
    endtask

    // Hold reset with requests asserted, check every output is quiet, then
    // release just after a rising edge.
    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        req = 2'b11;
        model_reset();
        @(negedge clk);
        check("rst_outs", {gnt, rsp_vld, mul_go, mul_op, rd, sat, nozero}, '0);
        check("rst_mul_opnds", mul_rm | mul_rn | mul_rh | mul_rs, '0);
        @(posedge clk);
        #1;
        req = '0;
        rst_n = 1;
    endtask

    int gseq[$];

    // Each requester issues `n` ops back to back; lock_all locks every op,
    // otherwise each op except the last is locked. Multiplier finishes at once.
    task automatic run_seq(input int n0, input int n1, input bit lock_all, input int cycles);
        int left[2];
        left[0] = n0; left[1] = n1;
        gseq.delete();
        mul_done = 1;
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < 2; i++) begin
                req[i]  = left[i] > 0;
                lock[i] = lock_all ? (left[i] > 0) : (left[i] > 1);
            end
            op[OPW-1:0]     = (left[0] > 1) ? OP_SMLALL : OP_SMLALH;
            op[2*OPW-1:OPW] = OP_UMLALL;
            step();
            for (int i = 0; i < 2; i++) begin
                if (s_gnt[i]) begin
                    gseq.push_back(i);
                    left[i]--;
                end
            end
        end
        idle_inputs();
    endtask

    task automatic check_order(input string tag, input int exp_q[$]);
        check({tag, "_len"}, gseq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < gseq.size(); i++) begin
            check($sformatf("%s_%0d", tag, i), gseq[i], exp_q[i]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int go_cnt, rsp_at;
        logic [31:0] rsp_rd;
        int exp_q[$];

        do_reset();

        // Single request: go high 3 cycles, response 5 cycles after grant.
        req = 2'b01; op[OPW-1:0] = OP_UMLALL; rm[31:0] = 32'd3; rs[31:0] = 32'd5;
        step();
        check("t1_gnt", s_gnt, 2'b01);
        req = '0;
        go_cnt = 0; rsp_at = -1; rsp_rd = '0;
        for (int k = 1; k <= 6; k++) begin
            mul_done = (k == 4);
            mul_rd   = (k == 4) ? 32'd3 * 32'd5 : 32'd0;
            step();
            if (s_go) go_cnt++;
            if (s_rsp != 2'b00) begin
                rsp_at = k;
                rsp_rd = s_rd;
                check("t1_rsp_owner", s_rsp, 2'b01);
            end
        end
        mul_done = 0;
        check("t1_go_cycles", go_cnt, 3);
        check("t1_latency", rsp_at, 5);
        check("t1_rd", rsp_rd, 32'd15);

        // Simultaneous requests twice
        do_reset();
        req = 2'b11;
        step();
        check("t2_first", s_gnt, 2'b01);
        req = 2'b10; mul_done = 1;
        step();
        mul_done = 0;
        step();
        req = 2'b11;
        step();
`ifdef ZAP_MUL_ARB_RR_EN
        check("t2_second", s_gnt, 2'b10);
`else
        check("t2_second", s_gnt, 2'b01);
`endif
        idle_inputs();
        mul_done = 1;
        for (int k = 0; k < 4; k++) step();
        mul_done = 0;

        // Locked pair from req0 ahead of pending req1
        do_reset();
        run_seq(2, 1, 1'b0, 20);
        exp_q = '{0, 0, 1};
        check_order("t3_order", exp_q);

        // Lock streak capped at LOCK_MAX
        do_reset();
        run_seq(4, 1, 1'b1, 30);
`ifdef ZAP_MUL_ARB_RR_EN
        exp_q = '{0, 0, 0, 1, 0};
`else
        exp_q = '{0, 0, 0, 0, 1};
`endif
        check_order("t4_order", exp_q);

        // Clear in the completion cycle
        do_reset();
        req = 2'b01;
        step();
        req = '0;
        step();
        clear = 1; mul_done = 1; mul_rd = 32'hdead;
        step();
        check("t5_rsp_clr", s_rsp, 2'b00);
        clear = 0; mul_done = 0; req = 2'b10;
        step();
        check("t5_rsp_next", s_rsp, 2'b00);
        check("t5_op_next", s_op, '0);
        check("t5_idle_gnt", s_gnt, 2'b10);
        req = '0; mul_done = 1;
        for (int k = 0; k < 3; k++) step();
        mul_done = 0;

        // Reset in the middle of a multiply
        do_reset();
        req = 2'b01; rm[31:0] = 32'h1234;
        step();
        req = '0;
        check("t6_go_before", mul_go, 1'b1);
        #2;
        rst_n = 0;
        #1;
        check("t6_go_async", mul_go, 1'b0);
        check("t6_outs", {gnt, rsp_vld, mul_op, rd, sat, nozero}, '0);
        check("t6_opnds", mul_rm | mul_rn | mul_rh | mul_rs, '0);
        do_reset();
        req = 2'b10;
        step();
        check("t6_gnt_after", s_gnt, 2'b10);
        req = '0; mul_done = 1;
        for (int k = 0; k < 3; k++) step();

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req[i] || s_gnt[i]) begin
                    req[i]  = ($urandom_range(0, 2) == 0);
                    lock[i] = $urandom_range(0, 1);
                    op[i*OPW +: OPW] = OPW'($urandom);
                    rm[i*32 +: 32] = $urandom;
                    rn[i*32 +: 32] = $urandom;
                    rh[i*32 +: 32] = $urandom;
                    rs[i*32 +: 32] = $urandom;
                end
            end
            mul_done   = ($urandom_range(0, 2) == 0);
            mul_rd     = $urandom;
            mul_sat    = $urandom_range(0, 1);
            mul_nozero = $urandom_range(0, 1);
            clear      = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
